// File: rtl/dram_rw_pkg.sv
// rtl/dram_rw_pkg.sv - shared state encoding and index sizing for DRAM shifter/reader blocks
package dram_rw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } rw_state_t;

  // A one-bit word still needs a one-bit index register.
  function automatic int idx_width(input int io_width);
    return (io_width > 1) ? $clog2(io_width) : 1;
  endfunction

endpackage

// File: rtl/dram_word_reader_if.sv
// rtl/dram_word_reader_if.sv - DRAM read port plus assembled-word valid/ready stream
interface dram_word_reader_if #(
  parameter int IO_WIDTH   = 16,
  parameter int ADDR_WIDTH = 5
);

  logic [ADDR_WIDTH-1:0] addr;
  logic                  ram_out;
  logic [IO_WIDTH-1:0]   out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    output addr,
    output out_data,
    output out_valid,
    input  ram_out,
    input  out_ready
  );

  modport master (
    input  addr,
    input  out_data,
    input  out_valid,
    output ram_out,
    output out_ready
  );

endinterface

// File: rtl/dram_addr_counter.sv
// rtl/dram_addr_counter.sv - bit index / RAM address register with terminal count at IO_WIDTH-1
module dram_addr_counter
  import dram_rw_pkg::*;
#(
  parameter int IO_WIDTH = 16,
  parameter int IDX_W    = idx_width(IO_WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_tc
);

  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_inc) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  assign o_idx = r_idx;
  assign o_tc  = (r_idx == IDX_W'(IO_WIDTH - 1));

endmodule

// File: rtl/dram_word_reader.sv
// rtl/dram_word_reader.sv - walks a 1-bit async-read DRAM port LSB first and presents the word on valid/ready
module dram_word_reader
  import dram_rw_pkg::*;
#(
  parameter int IO_WIDTH   = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int CONTINUOUS = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  dram_word_reader_if.slave   bus
);

  localparam int IDX_W = idx_width(IO_WIDTH);

  rw_state_t            r_state;
  rw_state_t            w_next;
  logic                 w_clr;
  logic                 w_inc;
  logic                 w_tc;
  logic                 w_hs;
  logic [IDX_W-1:0]     w_idx;
  logic [IO_WIDTH-1:0]  r_data;
  logic                 r_valid;

  dram_addr_counter #(
    .IO_WIDTH (IO_WIDTH),
    .IDX_W    (IDX_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_inc (w_inc),
    .o_idx (w_idx),
    .o_tc  (w_tc)
  );

  assign w_hs = r_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_inc  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_clr = 1'b1;
        if (start) begin
          w_next = READ;
        end
      end
      READ: begin
        if (w_tc) begin
          w_clr  = 1'b1;
          w_next = HOLD;
        end else begin
          w_inc = 1'b1;
        end
      end
      HOLD: begin
        if (w_hs) begin
          w_next = (CONTINUOUS != 0) ? READ : IDLE;
        end
      end
      default: begin
        w_clr  = 1'b1;
        w_next = IDLE;
      end
    endcase
  end

  // Unsampled bits keep the previous word; consumers only look while out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (r_state == READ) begin
      r_data[w_idx] <= bus.ram_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if ((r_state == READ) && w_tc) begin
      r_valid <= 1'b1;
    end else if (w_hs) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.addr      = ADDR_WIDTH'(w_idx);
  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_dram_word_reader.sv
// tb/tb_dram_word_reader.sv - scoreboard bench for dram_word_reader in one-shot, continuous and 32-bit configurations
module tb_dram_word_reader;

  localparam int IO_A = 16, AW_A = 5;
  localparam int IO_C = 32, AW_C = 5;

  if (IO_A > (1 << AW_A)) begin : g_bad_a
    $fatal(1, "illegal IO_WIDTH for config a");
  end
  if (IO_C > (1 << AW_C)) begin : g_bad_c
    $fatal(1, "illegal IO_WIDTH for config c");
  end

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic busy_a, busy_b, busy_c;
  logic [15:0] mem_a = 16'h0;
  logic [15:0] mem_b = 16'h0;
  logic [31:0] mem_c = 32'h0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dram_word_reader_if #(.IO_WIDTH(IO_A), .ADDR_WIDTH(AW_A)) if_a ();
  dram_word_reader_if #(.IO_WIDTH(IO_A), .ADDR_WIDTH(AW_A)) if_b ();
  dram_word_reader_if #(.IO_WIDTH(IO_C), .ADDR_WIDTH(AW_C)) if_c ();

  assign if_a.ram_out = mem_a[if_a.addr[3:0]];
  assign if_b.ram_out = mem_b[if_b.addr[3:0]];
  assign if_c.ram_out = mem_c[if_c.addr];

  dram_word_reader #(.IO_WIDTH(IO_A), .ADDR_WIDTH(AW_A), .CONTINUOUS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .bus(if_a));
  dram_word_reader #(.IO_WIDTH(IO_A), .ADDR_WIDTH(AW_A), .CONTINUOUS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .bus(if_b));
  dram_word_reader #(.IO_WIDTH(IO_C), .ADDR_WIDTH(AW_C), .CONTINUOUS(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .bus(if_c));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitors: a word is consumed at the edge following a negedge where valid && ready.
  always @(negedge clk) begin
    if (rst_n && if_a.out_valid && if_a.out_ready) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_word actual=%0h required=none", if_a.out_data);
      end else begin
        chk("a_word", 32'(if_a.out_data), qa.pop_front());
      end
    end
    if (rst_n && if_b.out_valid && if_b.out_ready) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_word actual=%0h required=none", if_b.out_data);
      end else begin
        chk("b_word", 32'(if_b.out_data), qb.pop_front());
      end
    end
    if (rst_n && if_c.out_valid && if_c.out_ready) begin
      if (qc.size() == 0) begin
        total++; bad++;
        $display("FAIL c_unexpected_word actual=%0h required=none", if_c.out_data);
      end else begin
        chk("c_word", if_c.out_data, qc.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t1, t2, n;
    if_a.out_ready = 1'b0;
    if_b.out_ready = 1'b0;
    if_c.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_addr", 32'(if_a.addr), 32'd0);
    chk("rst_valid", 32'(if_a.out_valid), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_data", 32'(if_a.out_data), 32'd0);

    // Async reset at index 7 mid-READ discards the partial word.
    mem_a = 16'hA5C3;
    if_a.out_ready = 1'b1;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("mid_read_addr", 32'(if_a.addr), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_addr", 32'(if_a.addr), 32'd0);
    chk("async_rst_valid", 32'(if_a.out_valid), 32'd0);
    chk("async_rst_busy", 32'(busy_a), 32'd0);
    chk("async_rst_data", 32'(if_a.out_data), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("post_rst_idle", 32'(busy_a), 32'd0);

    // Single read with address walk and latency.
    qa.push_back(32'h0000A5C3);
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    k = cyc;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("single_addr%0d", i), 32'(if_a.addr), 32'(i));
    end
    @(negedge clk);
    chk("single_valid", 32'(if_a.out_valid), 32'd1);
    chk("single_latency", 32'(cyc - k), 32'd16);
    chk("single_wrap_addr", 32'(if_a.addr), 32'd0);
    @(negedge clk);
    chk("single_valid_drop", 32'(if_a.out_valid), 32'd0);
    chk("single_idle", 32'(busy_a), 32'd0);

    // start pulses during READ are ignored.
    @(posedge clk); #1;
    qa.push_back(32'h0000A5C3);
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("ign_addr%0d", i), 32'(if_a.addr), 32'(i));
      start_a = (i == 1 || i == 9);
    end
    start_a = 1'b0;
    @(negedge clk);
    chk("ign_valid", 32'(if_a.out_valid), 32'd1);
    repeat (25) @(negedge clk);
    chk("ign_one_word", 32'(busy_a), 32'd0);

    // Backpressure: ready low for 5 valid cycles, handshake on the 6th.
    if_a.out_ready = 1'b0;
    qa.push_back(32'h0000A5C3);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n = 0;
    while (!if_a.out_valid && n < 40) begin @(negedge clk); n++; end
    chk("bp_valid_seen", 32'(if_a.out_valid), 32'd1);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("bp_valid%0d", j), 32'(if_a.out_valid), 32'd1);
      chk($sformatf("bp_data%0d", j), 32'(if_a.out_data), 32'h0000A5C3);
      @(posedge clk); #1;
    end
    if_a.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_valid_drop", 32'(if_a.out_valid), 32'd0);

    // CONTINUOUS: second word re-read with new RAM contents, 17 cycles apart.
    mem_b = 16'hA5C3;
    if_b.out_ready = 1'b1;
    qb.push_back(32'h0000A5C3);
    qb.push_back(32'h0000FFFF);
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0;
    while (!if_b.out_valid && n < 40) begin @(negedge clk); n++; end
    chk("cont_first_seen", 32'(if_b.out_valid), 32'd1);
    t1 = cyc;
    @(posedge clk); #1 mem_b = 16'hFFFF;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_b.out_valid && n < 40);
    chk("cont_second_seen", 32'(if_b.out_valid), 32'd1);
    t2 = cyc;
    chk("cont_spacing", 32'(t2 - t1), 32'd17);
    @(posedge clk); #1 if_b.out_ready = 1'b0;

    // 32-bit word fills the whole 32-deep RAM and wraps the address.
    mem_c = 32'h80000001;
    if_c.out_ready = 1'b1;
    qc.push_back(32'h80000001);
    start_c = 1'b1;
    @(posedge clk); #1 start_c = 1'b0;
    repeat (32) @(negedge clk);
    chk("wide_addr_top", 32'(if_c.addr), 32'd31);
    @(negedge clk);
    chk("wide_addr_wrap", 32'(if_c.addr), 32'd0);
    chk("wide_valid", 32'(if_c.out_valid), 32'd1);
    @(negedge clk);
    chk("wide_valid_drop", 32'(if_c.out_valid), 32'd0);

    repeat (5) @(negedge clk);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    chk("qc_drained", 32'(qc.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_word_reader.md
Name: dram_word_reader

Overview:
- Read-side counterpart to the serial RAM shifter. Walks the address bus of a 1-bit-wide distributed RAM port (RAM32M/RAM64M slice, asynchronous read) and samples one bit per cycle.
- Assembles the bits into an IO_WIDTH-bit word and presents it on a valid/ready output.
- Sits between a DRAM read port (addr/ram_out) and a consumer such as the LED driver or a checker.

Parameters:
- IO_WIDTH, 16, bits per assembled word; legal range 1..2**ADDR_WIDTH.
- ADDR_WIDTH, 5, RAM address width; 5 for RAM32M, 6 for RAM64M.
- CONTINUOUS, 0, 1 = restart a read immediately after each handshake; 0 = return to IDLE.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request one word read; sampled only in IDLE.
- addr  out  ADDR_WIDTH  RAM read address; registered.
- ram_out  in  1  RAM read data for addr; combinational (async read).
- out_data  out  IO_WIDTH  assembled word; registered, stable while out_valid.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts word.
- busy  out  1  high in READ or HOLD.

Behaviour:
- Reset (rst_n low, async): state=IDLE, addr=0, bit index=0, out_data=0, out_valid=0, busy=0. Reset mid-READ or mid-HOLD discards the partial or held word; no output follows reset.
- State machine:
  - IDLE: addr=0, busy=0. start=1 at edge k -> READ, index=0, addr=0.
  - READ: at each edge, out_data[index] <= ram_out, so bit i is read from address i (LSB first). If index < IO_WIDTH-1: index++, addr++. If index == IO_WIDTH-1: -> HOLD, out_valid<=1, addr<=0, index<=0.
  - HOLD: out_data and out_valid hold until out_valid && out_ready at an edge. At that edge out_valid<=0 and state -> READ if CONTINUOUS=1, else IDLE.
- Latency: start at edge k -> out_valid high after edge k+IO_WIDTH. Throughput with CONTINUOUS=1 and out_ready tied high is one word per IO_WIDTH+1 cycles.
- start is ignored in READ and HOLD; no queuing.
- Address never exceeds IO_WIDTH-1. It wraps to 0 after the last bit, with no modulo 2**ADDR_WIDTH overflow.
- IO_WIDTH > 2**ADDR_WIDTH is illegal; the bench flags it with an elaboration-time assertion.
- out_data bits not yet sampled in the current READ keep their previous word's values. Consumers only use out_data while out_valid=1.
- No combinational path from ram_out, start or out_ready to any output.

Decomposition:
- Shared package dram_rw_pkg holds:
  - state enum {IDLE, READ, HOLD};
  - localparam helper for index width, $clog2(IO_WIDTH) with minimum 1.
  The shifter/writer side reuses the same package.
- One natural sub-module: dram_addr_counter. Index/address register with clear, increment and terminal-count flag at IO_WIDTH-1.

Test Plan:
- Reset: hold rst_n low for 3 cycles mid-READ (index 7) -> addr=0, out_valid=0, busy=0, out_data=0 immediately, without waiting for a clock edge.
- Single read: RAM model preloaded with 0xA5C3 (bit i at address i), start pulse at edge 10, out_ready=1 -> addr sequences 0..15, out_valid rises after edge 26 for exactly 1 cycle, out_data=0xA5C3, back to IDLE.
- Backpressure: same pattern, out_ready low for 5 cycles after out_valid -> out_data stays 0xA5C3 and out_valid stays high for 5 cycles. Handshake on the 6th cycle, then out_valid=0.
- start ignored: pulse start at edges 12 and 20 during READ -> exactly one word is produced and addr is never reset mid-sequence.
- CONTINUOUS=1: RAM contents changed to 0xFFFF after the first handshake, out_ready=1 -> words 0xA5C3 then 0xFFFF with out_valid pulses 17 cycles apart.
- Boundary: IO_WIDTH=32, ADDR_WIDTH=5, RAM = 0x8000_0001 -> addr reaches 31 then wraps to 0, out_data=0x8000_0001.
